// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port unified memory between MIPS
// instruction fetch and load/store data access. Each transaction is held on
// the memory port for WAIT_CYCLES cycles, then the owner gets a one-cycle ack
// along with any read data. Data has priority over fetch. A starvation
// counter forces a fetch grant after STARVE_MAX back-to-back data grants that
// were made while a fetch was waiting.
module mips_mem_arbiter #(
   parameter int WAIT_CYCLES = 2,
   parameter int STARVE_MAX  = 4
) (
   input  logic        globalclock,
   input  logic        globalreset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          own_data_q, own_data_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;
   logic          if_ack_q, if_ack_d;
   logic          d_ack_q, d_ack_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          busy_q, busy_d;

   // Next-state, grant selection and next values of every registered output.
   // Memory-port outputs are computed one cycle ahead so they are flop-driven
   // yet still line up exactly with the ACCESS cycles.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      starve_d    = starve_q;
      own_data_d  = own_data_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_ack_d    = 1'b0;
      d_ack_d     = 1'b0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = 32'd0;
      mem_wdata_d = 32'd0;
      busy_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (d_req || if_req) begin
               if (d_req && !(if_req && (starve_q == SW'(STARVE_MAX)))) begin
                  own_data_d = 1'b1;
                  we_d       = d_we;
                  addr_d     = d_addr;
                  wdata_d    = d_wdata;
                  if (if_req) begin
                     starve_d = starve_q + SW'(1);
                  end else begin
                     starve_d = SW'(0);
                  end
               end else begin
                  own_data_d = 1'b0;
                  we_d       = 1'b0;
                  addr_d     = if_addr;
                  wdata_d    = 32'd0;
                  starve_d   = SW'(0);
               end
               cnt_d       = CW'(0);
               state_d     = S_ACCESS;
               mem_en_d    = 1'b1;
               mem_we_d    = we_d;
               mem_addr_d  = addr_d & 32'hFFFF_FFFC;
               mem_wdata_d = wdata_d;
            end else begin
               // if_req is low here, so nothing is waiting to be starved.
               starve_d = SW'(0);
            end
         end
         S_ACCESS: begin
            if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
               // Last access cycle: mem_rdata is valid now.
               state_d = S_RESP;
               if (own_data_q) begin
                  d_ack_d = 1'b1;
                  if (!we_q) begin
                     d_rdata_d = mem_rdata;
                  end else begin
                     d_rdata_d = d_rdata_q;
                  end
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d       = cnt_q + CW'(1);
               mem_en_d    = 1'b1;
               mem_we_d    = we_q;
               mem_addr_d  = addr_q & 32'hFFFF_FFFC;
               mem_wdata_d = wdata_q;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d != S_IDLE) begin
         busy_d = 1'b1;
      end else begin
         busy_d = 1'b0;
      end
   end

   // State and output registers; reset aborts any transaction with no ack.
   always_ff @(posedge globalclock or posedge globalreset) begin
      if (globalreset) begin
         state_q     <= S_IDLE;
         cnt_q       <= CW'(0);
         starve_q    <= SW'(0);
         own_data_q  <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         if_rdata_q  <= 32'd0;
         d_rdata_q   <= 32'd0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         starve_q    <= starve_d;
         own_data_q  <= own_data_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_ack_q    <= if_ack_d;
         d_ack_q     <= d_ack_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_ack    = if_ack_q;
   assign d_ack     = d_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule
